// File: rtl/hcm_road_readout_pkg.sv
// Shared definitions for the HCM road readout: parameter defaults, the HCM word
// field offsets, derived-width helpers and the FSM state encoding.
package hcm_road_readout_pkg;

  localparam int ROWINDEXBITS_HCM_DEF = 14;
  localparam int MAXHITNBITS_DEF      = 3;
  localparam int ROWINDEXBITS_HIM_DEF = 8;
  localparam int HITINFOBITS_DEF      = 16;
  localparam int HIM_READDELAY_DEF    = 2;

  // The HCM word is {himAddr, nHits}, with the hit count in the low bits.
  localparam int HCM_NHITS_LSB = 0;

  function automatic int maxHits(input int nBits);
    return (1 << nBits) - 1;
  endfunction

  function automatic int hcmAddrLsb(input int nBits);
    return HCM_NHITS_LSB + nBits;
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HCM_WAIT  = 2'd1,
    HIM_WAIT  = 2'd2,
    SERIALIZE = 2'd3
  } state_t;

endpackage

// File: rtl/hcm_road_readout_hit_serializer.sv
// Holds one HIM row and presents its hit records one at a time, lowest record
// first, advancing only on a valid/ready handshake.
module hit_serializer import hcm_road_readout_pkg::*; #(
  parameter int MAXHITNBITS = MAXHITNBITS_DEF,
  parameter int HITINFOBITS = HITINFOBITS_DEF,
  parameter int NCOLS_HIM   = HITINFOBITS_DEF * maxHits(MAXHITNBITS_DEF)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic [NCOLS_HIM-1:0]   loadData,
  input  logic [MAXHITNBITS-1:0] loadCount,
  input  logic                   hitReady,
  output logic                   hitValid,
  output logic [HITINFOBITS-1:0] hitInfo,
  output logic                   hitLast
);

  logic [NCOLS_HIM-1:0]   shiftReg;
  logic [MAXHITNBITS-1:0] idx;
  logic [MAXHITNBITS-1:0] count;

  // loadCount is never zero here, so count-1 cannot underflow and idx never wraps.
  assign hitInfo = shiftReg[HITINFOBITS-1:0];
  assign hitLast = hitValid && (idx == count - 1'b1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shiftReg <= '0;
      idx      <= '0;
      count    <= '0;
      hitValid <= 1'b0;
    end else if (load) begin
      shiftReg <= loadData;
      idx      <= '0;
      count    <= loadCount;
      hitValid <= 1'b1;
    end else if (hitValid && hitReady) begin
      if (hitLast) begin
        shiftReg <= '0;
        idx      <= '0;
        hitValid <= 1'b0;
      end else begin
        shiftReg <= shiftReg >> HITINFOBITS;
        idx      <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hcm_road_readout.sv
// Road readout: looks up a road in the HCM, fetches its hits from the HIM and
// streams them out. Define HCM_READOUT_ROWCHECK_EN to verify the HCM echo row.
// Handshakes: a transfer happens on any rising edge where valid and ready are both 1;
// a producer holds valid and its payload stable until that edge.
module hcm_road_readout import hcm_road_readout_pkg::*; #(
  parameter int ROWINDEXBITS_HCM = ROWINDEXBITS_HCM_DEF,
  parameter int MAXHITNBITS      = MAXHITNBITS_DEF,
  parameter int ROWINDEXBITS_HIM = ROWINDEXBITS_HIM_DEF,
  parameter int HITINFOBITS      = HITINFOBITS_DEF,
  parameter int HIM_READDELAY    = HIM_READDELAY_DEF,
  localparam int MAXHITS   = maxHits(MAXHITNBITS),
  localparam int NCOLS_HCM = MAXHITNBITS + ROWINDEXBITS_HIM,
  localparam int NCOLS_HIM = HITINFOBITS * MAXHITS
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        reqValid,
  input  logic [ROWINDEXBITS_HCM-1:0] reqRow,
  output logic                        reqReady,
  output logic                        hcmReadRow,
  output logic [ROWINDEXBITS_HCM-1:0] hcmRowToRead,
  input  logic                        hcmNewOutput,
  input  logic [ROWINDEXBITS_HCM-1:0] hcmRowPassed,
  input  logic [NCOLS_HCM-1:0]        hcmRowData,
  output logic                        himRead,
  output logic [ROWINDEXBITS_HIM-1:0] himAddr,
  input  logic [NCOLS_HIM-1:0]        himData,
  output logic                        hitValid,
  input  logic                        hitReady,
  output logic [HITINFOBITS-1:0]      hitInfo,
  output logic                        hitLast,
  output logic [ROWINDEXBITS_HCM-1:0] hitRow,
  output logic                        emptyRoad,
  output logic                        rowError,
  output logic [1:0]                  stateDbg
);

  localparam int ADDR_LSB = hcmAddrLsb(MAXHITNBITS);
  localparam int DW       = $clog2(HIM_READDELAY + 2);

  state_t                      state;
  logic [ROWINDEXBITS_HCM-1:0] latchedRow;
  logic [MAXHITNBITS-1:0]      nHitsReg;
  logic [DW-1:0]               waitCnt;
  logic [MAXHITNBITS-1:0]      hcmNHits;
  logic                        rowOk;
  logic                        himLoad;
  logic                        roadDone;

  assign hcmNHits = hcmRowData[HCM_NHITS_LSB +: MAXHITNBITS];
  assign reqReady = (state == IDLE);
  assign stateDbg = state;
  assign hitRow   = latchedRow;
  assign himLoad  = (state == HIM_WAIT) && (waitCnt == DW'(HIM_READDELAY));
  assign roadDone = hitValid && hitReady && hitLast;

`ifdef HCM_READOUT_ROWCHECK_EN
  assign rowOk = (hcmRowPassed == latchedRow);

  // A mismatched echo is dropped; the FSM keeps waiting for the right row.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      rowError <= 1'b0;
    else if (state == HCM_WAIT && hcmNewOutput && !rowOk)
      rowError <= 1'b1;
  end
`else
  logic unusedRowPassed;
  assign unusedRowPassed = ^hcmRowPassed;
  assign rowOk           = 1'b1;
  assign rowError        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      latchedRow   <= '0;
      nHitsReg     <= '0;
      waitCnt      <= '0;
      hcmReadRow   <= 1'b0;
      hcmRowToRead <= '0;
      himRead      <= 1'b0;
      himAddr      <= '0;
      emptyRoad    <= 1'b0;
    end else begin
      hcmReadRow <= 1'b0;
      himRead    <= 1'b0;
      emptyRoad  <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            latchedRow   <= reqRow;
            hcmRowToRead <= reqRow;
            hcmReadRow   <= 1'b1;
            state        <= HCM_WAIT;
          end
        end
        HCM_WAIT: begin
          if (hcmNewOutput && rowOk) begin
            nHitsReg <= hcmNHits;
            if (hcmNHits == '0) begin
              emptyRoad <= 1'b1;
              state     <= IDLE;
            end else begin
              himRead <= 1'b1;
              himAddr <= hcmRowData[ADDR_LSB +: ROWINDEXBITS_HIM];
              waitCnt <= '0;
              state   <= HIM_WAIT;
            end
          end
        end
        HIM_WAIT: begin
          if (himLoad)
            state <= SERIALIZE;
          else
            waitCnt <= waitCnt + 1'b1;
        end
        SERIALIZE: begin
          if (roadDone)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hit_serializer #(
    .MAXHITNBITS (MAXHITNBITS),
    .HITINFOBITS (HITINFOBITS),
    .NCOLS_HIM   (NCOLS_HIM)
  ) u_hit_serializer (
    .clk       (clk),
    .resetN    (resetN),
    .load      (himLoad),
    .loadData  (himData),
    .loadCount (nHitsReg),
    .hitReady  (hitReady),
    .hitValid  (hitValid),
    .hitInfo   (hitInfo),
    .hitLast   (hitLast)
  );

endmodule
